latch_bank_write_ctrl: RTL and testbench

Sequences writes into a bank of 2**AW transparent D latches, each DW bits wide. The bank is shared by NREQ requesters through round-robin arbitration. For each granted write the block drives the latch data bus and opens exactly one latch enable. Data is stable for setup cycles before the enable opens and for hold cycles after it closes, so no latch ever sees data change while it is transparent.

---
 rtl/latch_ctrl_pkg.sv | 45 ++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/latch_bank_write_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and helpers for the latch bank write controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package latch_ctrl_pkg;

  // Write sequence phases; anything other than IDLE means the bank is in use.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Default geometry and phase lengths.
  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_AW        = 3;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 1;
  localparam int DEF_HOLD_CYC  = 1;

  // Largest address width the decoder supports; callers truncate the result
  // down to their own bank size.
  localparam int MAX_AW   = 8;
  localparam int MAX_NLAT = 1 << MAX_AW;

  // Address to one-hot enable vector.
  function automatic logic [MAX_NLAT-1:0] onehot_decode(input logic [MAX_AW-1:0] a);
    logic [MAX_NLAT-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Largest of three phase lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first asserted request at or after ptr, wrapping.
// Latency: purely combinational; the rotating pointer lives in the parent.
// Backpressure: none; losers simply stay unselected until a later evaluation.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic            win_vld
);

  // Walk the requesters starting at ptr and take the first one found.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    win_oh  = '0;
    win_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ and i < NREQ, so one subtraction is enough to wrap.
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win_oh[idx] = 1'b1;
        win_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Arbitrates NREQ writers onto a bank of transparent latches, one latch opened per write.
// Latency: grant one edge after req seen in IDLE; done after SETUP+OPEN+HOLD+1 grant cycles.
// Backpressure: requesters hold req until their done; others wait, at least one idle cycle between writes.
module latch_bank_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [(1<<AW)-1:0]   lat_en,
  output logic [DW-1:0]        lat_d,
  output logic                 busy
);

  localparam int NLAT = 1 << AW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = max3(SETUP_CYC, OPEN_CYC, HOLD_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  // Terminal counts for each phase; the counter restarts at 0 on every state change.
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NLAT-1:0] lat_en_q, lat_en_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] arb_oh;
  logic            arb_vld;
  logic [PW-1:0]   arb_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_vld (arb_vld)
  );

  // Turn the one-hot winner into an index and pick out its address and data.
  always_comb begin
    arb_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) begin
        arb_idx  = PW'(i);
        sel_addr = addr[i*AW +: AW];
        sel_data = wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and registered.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q + 1'b1;
    gnt_d    = gnt_q;
    done_d   = '0;
    lat_en_d = lat_en_q;
    lat_d_d  = lat_d_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        gnt_d    = '0;
        lat_en_d = '0;
        lat_d_d  = '0;
        // Address and data are captured only here; later input changes are ignored.
        if (arb_vld) begin
          gnt_d   = arb_oh;
          win_d   = arb_idx;
          addr_d  = sel_addr;
          lat_d_d = sel_data;
          state_d = SETUP;
        end
      end

      SETUP: begin
        // Enable rises on the edge that enters OPEN, after data has settled.
        if (cnt_q == SETUP_LAST) begin
          state_d  = OPEN;
          cnt_d    = '0;
          lat_en_d = NLAT'(onehot_decode(MAX_AW'(addr_q)));
        end
      end

      OPEN: begin
        if (cnt_q == OPEN_LAST) begin
          state_d  = HOLD;
          cnt_d    = '0;
          lat_en_d = '0;
        end
      end

      HOLD: begin
        // Data is still driven here so the closing latch never sees it move.
        if (cnt_q == HOLD_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = gnt_q;
        end
      end

      DONE: begin
        // Advance past the winner so every requester is served within NREQ writes.
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        lat_d_d = '0;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        gnt_d    = '0;
        lat_en_d = '0;
        lat_d_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops every output, including an open enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      lat_en_q <= '0;
      lat_d_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      lat_en_q <= lat_en_d;
      lat_d_q  <= lat_d_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign lat_en = lat_en_q;
  assign lat_d  = lat_d_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Scoreboard bench: stimulus queues expected write records, a negedge monitor
// reconstructs each grant window from the pins and checks it when done pulses.
// Instance a uses default phase lengths, instance b uses 2/3/2.
`timescale 1ns/1ps
module tb_latch_bank_write_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [11:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  gnt_a, gnt_b, done_a, done_b;
  logic [7:0]  en_a, en_b, d_a, d_b;
  logic        busy_a, busy_b;

  latch_bank_write_ctrl u_a (
    .clk(clk), .rst(rst_a), .req(req_a), .addr(addr_a), .wdata(wdata_a),
    .gnt(gnt_a), .done(done_a), .lat_en(en_a), .lat_d(d_a), .busy(busy_a)
  );

  latch_bank_write_ctrl #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst(rst_b), .req(req_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .done(done_b), .lat_en(en_b), .lat_d(d_b), .busy(busy_b)
  );

  typedef struct {
    int         dut;
    int         rq;
    logic [7:0] data;
    logic [7:0] en;
    int         len;
    int         open;
    int         start;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic push(input int dut, input int rq, input logic [7:0] data,
                      input logic [7:0] en, input int len, input int open,
                      input int start, input int gap);
    exp_t e;
    e.dut = dut; e.rq = rq; e.data = data; e.en = en;
    e.len = len; e.open = open; e.start = start; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  // Monitor view of both instances.
  logic [3:0] m_gnt[2], m_done[2];
  logic [7:0] m_en[2], m_d[2];
  logic       m_rst[2];
  assign m_gnt[0] = gnt_a;  assign m_gnt[1] = gnt_b;
  assign m_done[0] = done_a; assign m_done[1] = done_b;
  assign m_en[0] = en_a;    assign m_en[1] = en_b;
  assign m_d[0] = d_a;      assign m_d[1] = d_b;
  assign m_rst[0] = rst_a;  assign m_rst[1] = rst_b;

  always @(posedge clk) cyc <= cyc + 1;

  bit         in_t[2];
  bit         dbad[2], ebad[2];
  int         glen[2], ecnt[2], estart[2], elast[2], last_done[2];
  logic [3:0] gv[2];
  logic [7:0] d0[2], ev[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!m_rst[k]) begin
        in_t[k] = 1'b0;
      end else begin
        if (in_t[k] && m_gnt[k] == 4'd0) in_t[k] = 1'b0;
        if (!in_t[k] && m_gnt[k] != 4'd0) begin
          in_t[k] = 1'b1; glen[k] = 0; ecnt[k] = 0; estart[k] = 0; elast[k] = 0;
          gv[k] = m_gnt[k]; d0[k] = m_d[k]; ev[k] = '0; dbad[k] = 1'b0; ebad[k] = 1'b0;
        end
        if (!in_t[k]) begin
          if (m_en[k] != 8'd0 || m_done[k] != 4'd0 || m_d[k] != 8'd0)
            chk($sformatf("idle_quiet%0d", k), {m_done[k], m_en[k], m_d[k]}, 0);
        end else begin
          glen[k]++;
          if (m_gnt[k] != gv[k] || m_d[k] != d0[k]) dbad[k] = 1'b1;
          if (m_en[k] != 8'd0) begin
            if (!$onehot(m_en[k])) ebad[k] = 1'b1;
            if (ecnt[k] != 0 && (m_en[k] != ev[k] || elast[k] != glen[k] - 1)) ebad[k] = 1'b1;
            if (ecnt[k] == 0) estart[k] = glen[k];
            ev[k] = m_en[k];
            ecnt[k]++;
            elast[k] = glen[k];
          end
          if (m_done[k] != 4'd0) begin
            if (sb.size() == 0 || sb[0].dut != k) begin
              chk($sformatf("unexpected_done%0d", k), m_done[k], 0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("done_req",   m_done[k], 1 << e.rq);
              chk("gnt_req",    gv[k], 1 << e.rq);
              chk("lat_d",      d0[k], e.data);
              chk("lat_en",     ev[k], e.en);
              chk("gnt_len",    glen[k], e.len);
              chk("open_len",   ecnt[k], e.open);
              chk("open_start", estart[k], e.start);
              chk("stable",     dbad[k], 0);
              chk("en_clean",   ebad[k], 0);
              if (e.gap != 0) chk("done_gap", cyc - last_done[k], e.gap);
            end
            last_done[k] = cyc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 4'b1111; req_b = 4'b0000;
    addr_a  = {3'd7, 3'd6, 3'd2, 3'd1};
    wdata_a = 32'h4433_2211;
    addr_b  = '0;
    wdata_b = '0;

    // Reset held with all requests high: everything quiet.
    repeat (2) @(negedge clk);
    chk("rst_gnt",  gnt_a, 0);
    chk("rst_en",   en_a, 0);
    chk("rst_d",    d_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_busy", busy_b, 0);

    // Round robin with all requests held: 0,1,2,3,0 spaced 5 cycles apart.
    push(0, 0, 8'h11, 8'h02, 4, 1, 2, 0);
    push(0, 1, 8'h22, 8'h04, 4, 1, 2, 5);
    push(0, 2, 8'h33, 8'h40, 4, 1, 2, 5);
    push(0, 3, 8'h44, 8'h80, 4, 1, 2, 5);
    push(0, 0, 8'h11, 8'h02, 4, 1, 2, 5);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("first_grant", gnt_a, 4'b0001);
    chk("first_busy", busy_a, 1);
    wait_drain(200);
    req_a = 4'b0000;

    // Single write: requester 2, address 5, data A5.
    addr_a[8:6]     = 3'd5;
    wdata_a[23:16]  = 8'hA5;
    push(0, 2, 8'hA5, 8'h20, 4, 1, 2, 0);
    req_a = 4'b0100;
    wait_drain(50);
    req_a = 4'b0000;

    // Inputs change and req drops after the grant; captured values must win.
    addr_a[5:3]    = 3'd3;
    wdata_a[15:8]  = 8'h3C;
    push(0, 1, 8'h3C, 8'h08, 4, 1, 2, 0);
    req_a = 4'b0010;
    n = 0;
    while (gnt_a[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("grant1_seen", gnt_a[1], 1);
    wdata_a[15:8] = 8'hFF;
    req_a = 4'b0000;
    wait_drain(50);

    // Reset while the enable is open: enable drops, no done, pointer back to 0.
    req_a = 4'b1000;
    n = 0;
    while (en_a === 8'd0 && n < 50) begin @(negedge clk); n++; end
    chk("open_seen", en_a, 8'h80);
    rst_a = 1'b0;
    req_a = 4'b0000;
    @(negedge clk);
    chk("midrst_en",   en_a, 0);
    chk("midrst_gnt",  gnt_a, 0);
    chk("midrst_busy", busy_a, 0);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nodone", done_a, 0);
    // With pointer at 0, requester 1 beats requester 3.
    push(0, 1, 8'hFF, 8'h08, 4, 1, 2, 0);
    req_a = 4'b1010;
    wait_drain(50);
    req_a = 4'b0000;

    // Longer phases: gnt 8 cycles, enable 3 cycles starting at the 3rd grant cycle.
    addr_b[2:0]  = 3'd4;
    wdata_b[7:0] = 8'h5A;
    push(1, 0, 8'h5A, 8'h10, 8, 3, 3, 0);
    req_b = 4'b0001;
    wait_drain(100);
    req_b = 4'b0000;

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("end_busy_a", busy_a, 0);
    chk("end_busy_b", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
